// File: rtl/mpeg_video_display_scheduler.sv
// mpeg_video_display_scheduler
// Frame-buffer slot scheduler: offers free slots to the picture decoder and,
// on each vsync, releases decoded pictures in temporal-reference order.
// Optional feature macro: MPEG_DISPLAY_STATS_EN adds the underflow_count output.
module mpeg_video_display_scheduler #(
    parameter int SLOTS = 4,
    parameter int SW    = $clog2(SLOTS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          event_sequence_header,
    input  logic          event_group_of_pictures,
    input  logic          event_picture,
    input  logic [9:0]    tmpref,
    output logic          alloc_valid,
    output logic [SW-1:0] alloc_slot,
    output logic [9:0]    alloc_tmpref,
    input  logic          alloc_ready,
    input  logic          decode_done,
    input  logic [SW-1:0] decode_slot,
    input  logic          vsync,
    output logic          display_valid,
    output logic          display_repeat,
    output logic [SW-1:0] display_slot,
    output logic          stall
`ifdef MPEG_DISPLAY_STATS_EN
    ,
    output logic [15:0]   underflow_count
`endif
);

    typedef enum logic [1:0] {S_FREE, S_ALLOC, S_READY, S_SHOWN} slot_st_e;
    typedef enum logic [1:0] {D_IDLE, D_SEARCH, D_SWITCH, D_EMIT} disp_st_e;

    slot_st_e      st_q  [SLOTS];
    slot_st_e      st_d  [SLOTS];
    logic [9:0]    tmp_q [SLOTS];
    logic [9:0]    tmp_d [SLOTS];
    logic [SLOTS-1:0] gen_q, gen_d;

    logic          pending_q, pending_d;
    logic [9:0]    ptmp_q, ptmp_d;
    logic          gen_in_q, gen_in_d;
    logic          gen_out_q, gen_out_d;
    logic [9:0]    exp_q, exp_d;

    logic          alloc_valid_q, alloc_valid_d;
    logic [SW-1:0] alloc_slot_q, alloc_slot_d;
    logic [9:0]    alloc_tmpref_q, alloc_tmpref_d;

    disp_st_e      dstate_q, dstate_d;
    logic          hit_q, hit_d;
    logic [SW-1:0] hit_slot_q, hit_slot_d;
    logic          switched_q, switched_d;
    logic          disp_valid_q, disp_valid_d;
    logic          disp_repeat_q, disp_repeat_d;
    logic [SW-1:0] disp_slot_q, disp_slot_d;

    logic          hit_any, live_any, free_any, free_eff_any, emit_hit;
    logic [SW-1:0] hit_idx, free_eff_idx;

    // Parallel slot compare: display hit, live pictures of gen_out, free slots.
    // The slot being released by an EMIT this cycle already counts as free.
    always_comb begin
        hit_any      = 1'b0;
        hit_idx      = '0;
        live_any     = 1'b0;
        free_any     = 1'b0;
        free_eff_any = 1'b0;
        free_eff_idx = '0;
        emit_hit     = (dstate_q == D_EMIT) && hit_q;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (st_q[i] == S_READY && gen_q[i] == gen_out_q && tmp_q[i] == exp_q) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
            if ((st_q[i] == S_ALLOC || st_q[i] == S_READY) && gen_q[i] == gen_out_q)
                live_any = 1'b1;
            if (st_q[i] == S_FREE)
                free_any = 1'b1;
            if (st_q[i] == S_FREE || (emit_hit && st_q[i] == S_SHOWN)) begin
                free_eff_any = 1'b1;
                free_eff_idx = SW'(i);
            end
        end
    end

    // Next state: allocation, decode completion, display FSM, then flush, GOP, picture capture.
    always_comb begin
        st_d           = st_q;
        tmp_d          = tmp_q;
        gen_d          = gen_q;
        pending_d      = pending_q;
        ptmp_d         = ptmp_q;
        gen_in_d       = gen_in_q;
        gen_out_d      = gen_out_q;
        exp_d          = exp_q;
        alloc_valid_d  = alloc_valid_q;
        alloc_slot_d   = alloc_slot_q;
        alloc_tmpref_d = alloc_tmpref_q;
        dstate_d       = dstate_q;
        hit_d          = hit_q;
        hit_slot_d     = hit_slot_q;
        switched_d     = switched_q;
        disp_valid_d   = 1'b0;
        disp_repeat_d  = 1'b0;
        disp_slot_d    = disp_slot_q;

        if (alloc_valid_q && alloc_ready) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (alloc_slot_q == SW'(i)) begin
                    st_d[i]  = S_ALLOC;
                    tmp_d[i] = alloc_tmpref_q;
                    gen_d[i] = gen_in_q;
                end
            end
            alloc_valid_d = 1'b0;
            pending_d     = 1'b0;
        end else if (pending_q && !alloc_valid_q && free_eff_any) begin
            alloc_valid_d  = 1'b1;
            alloc_slot_d   = free_eff_idx;
            alloc_tmpref_d = ptmp_q;
        end

        if (decode_done) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (decode_slot == SW'(i) && st_q[i] == S_ALLOC)
                    st_d[i] = S_READY;
            end
        end

        case (dstate_q)
            D_IDLE: begin
                if (vsync) begin
                    dstate_d   = D_SEARCH;
                    switched_d = 1'b0;
                end
            end
            D_SEARCH: begin
                if (hit_any) begin
                    hit_d        = 1'b1;
                    hit_slot_d   = hit_idx;
                    disp_valid_d = 1'b1;
                    disp_slot_d  = hit_idx;
                    dstate_d     = D_EMIT;
                end else if (!live_any && (gen_in_q != gen_out_q) && !switched_q) begin
                    dstate_d = D_SWITCH;
                end else begin
                    hit_d         = 1'b0;
                    disp_repeat_d = 1'b1;
                    dstate_d      = D_EMIT;
                end
            end
            D_SWITCH: begin
                gen_out_d  = ~gen_out_q;
                exp_d      = '0;
                switched_d = 1'b1;
                dstate_d   = D_SEARCH;
            end
            D_EMIT: begin
                if (hit_q) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (st_q[i] == S_SHOWN)
                            st_d[i] = S_FREE;
                        if (hit_slot_q == SW'(i))
                            st_d[i] = S_SHOWN;
                    end
                    exp_d = exp_q + 10'd1;
                end
                dstate_d = D_IDLE;
            end
            default: dstate_d = D_IDLE;
        endcase

        if (event_sequence_header) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (st_d[i] == S_ALLOC || st_d[i] == S_READY)
                    st_d[i] = S_FREE;
            end
            pending_d     = 1'b0;
            alloc_valid_d = 1'b0;
            exp_d         = '0;
            gen_out_d     = gen_in_q;
            dstate_d      = D_IDLE;
            disp_valid_d  = 1'b0;
            disp_repeat_d = 1'b0;
            disp_slot_d   = disp_slot_q;
        end

        if (event_group_of_pictures)
            gen_in_d = ~gen_in_q;

        if (event_picture && (!pending_q || event_sequence_header)) begin
            pending_d = 1'b1;
            ptmp_d    = tmpref;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                st_q[i]  <= S_FREE;
                tmp_q[i] <= '0;
            end
            gen_q          <= '0;
            pending_q      <= 1'b0;
            ptmp_q         <= '0;
            gen_in_q       <= 1'b0;
            gen_out_q      <= 1'b0;
            exp_q          <= '0;
            alloc_valid_q  <= 1'b0;
            alloc_slot_q   <= '0;
            alloc_tmpref_q <= '0;
            dstate_q       <= D_IDLE;
            hit_q          <= 1'b0;
            hit_slot_q     <= '0;
            switched_q     <= 1'b0;
            disp_valid_q   <= 1'b0;
            disp_repeat_q  <= 1'b0;
            disp_slot_q    <= '0;
        end else begin
            st_q           <= st_d;
            tmp_q          <= tmp_d;
            gen_q          <= gen_d;
            pending_q      <= pending_d;
            ptmp_q         <= ptmp_d;
            gen_in_q       <= gen_in_d;
            gen_out_q      <= gen_out_d;
            exp_q          <= exp_d;
            alloc_valid_q  <= alloc_valid_d;
            alloc_slot_q   <= alloc_slot_d;
            alloc_tmpref_q <= alloc_tmpref_d;
            dstate_q       <= dstate_d;
            hit_q          <= hit_d;
            hit_slot_q     <= hit_slot_d;
            switched_q     <= switched_d;
            disp_valid_q   <= disp_valid_d;
            disp_repeat_q  <= disp_repeat_d;
            disp_slot_q    <= disp_slot_d;
        end
    end

    assign alloc_valid    = alloc_valid_q;
    assign alloc_slot     = alloc_slot_q;
    assign alloc_tmpref   = alloc_tmpref_q;
    assign display_valid  = disp_valid_q;
    assign display_repeat = disp_repeat_q;
    assign display_slot   = disp_slot_q;
    assign stall          = pending_q && !alloc_valid_q && !free_any;

`ifdef MPEG_DISPLAY_STATS_EN
    logic [15:0] uf_q, uf_d;

    // Saturating count of repeated frames; cleared by a sequence header.
    always_comb begin
        uf_d = uf_q;
        if (event_sequence_header)
            uf_d = '0;
        else if (disp_repeat_d && uf_q != 16'hFFFF)
            uf_d = uf_q + 16'd1;
    end

    // Underflow counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            uf_q <= '0;
        else
            uf_q <= uf_d;
    end

    assign underflow_count = uf_q;
`endif

endmodule

// File: tb/tb_mpeg_video_display_scheduler.sv
// Bench for mpeg_video_display_scheduler: directed scenarios followed by a
// randomized phase, all checked against a transaction-level slot model.
`timescale 1ns/1ps
module tb_mpeg_video_display_scheduler;

    localparam int SLOTS = 4;
    localparam int SW    = 2;
    localparam int F = 0, A = 1, R = 2, SH = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          event_sequence_header = 1'b0;
    logic          event_group_of_pictures = 1'b0;
    logic          event_picture = 1'b0;
    logic [9:0]    tmpref = '0;
    logic          alloc_valid;
    logic [SW-1:0] alloc_slot;
    logic [9:0]    alloc_tmpref;
    logic          alloc_ready = 1'b0;
    logic          decode_done = 1'b0;
    logic [SW-1:0] decode_slot = '0;
    logic          vsync = 1'b0;
    logic          display_valid;
    logic          display_repeat;
    logic [SW-1:0] display_slot;
    logic          stall;
`ifdef MPEG_DISPLAY_STATS_EN
    logic [15:0]   underflow_count;
`endif

    mpeg_video_display_scheduler #(.SLOTS(SLOTS)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .event_sequence_header(event_sequence_header),
        .event_group_of_pictures(event_group_of_pictures),
        .event_picture(event_picture),
        .tmpref(tmpref),
        .alloc_valid(alloc_valid),
        .alloc_slot(alloc_slot),
        .alloc_tmpref(alloc_tmpref),
        .alloc_ready(alloc_ready),
        .decode_done(decode_done),
        .decode_slot(decode_slot),
        .vsync(vsync),
        .display_valid(display_valid),
        .display_repeat(display_repeat),
        .display_slot(display_slot),
        .stall(stall)
`ifdef MPEG_DISPLAY_STATS_EN
        , .underflow_count(underflow_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slot states, tmprefs, generations and scheduler registers.
    int mst [SLOTS];
    int mtmp[SLOTS];
    int mgen[SLOTS];
    int mpend, mptmp, m_gin, m_gout, m_exp, m_disp, m_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < SLOTS; i++) begin
            mst[i] = F; mtmp[i] = 0; mgen[i] = 0;
        end
        mpend = 0; mptmp = 0; m_gin = 0; m_gout = 0; m_exp = 0; m_disp = 0; m_uf = 0;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < SLOTS; i++) if (mst[i] == F) return i;
        return -1;
    endfunction

    function automatic int find_hit();
        for (int i = 0; i < SLOTS; i++)
            if (mst[i] == R && mgen[i] == m_gout && mtmp[i] == m_exp) return i;
        return -1;
    endfunction

    function automatic bit live_out();
        for (int i = 0; i < SLOTS; i++)
            if ((mst[i] == A || mst[i] == R) && mgen[i] == m_gout) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit dup_in(input int t);
        for (int i = 0; i < SLOTS; i++)
            if ((mst[i] == A || mst[i] == R) && mgen[i] == m_gin && mtmp[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mdl_flush();
        for (int i = 0; i < SLOTS; i++) if (mst[i] == A || mst[i] == R) mst[i] = F;
        mpend = 0; m_exp = 0; m_gout = m_gin; m_uf = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_av"}, alloc_valid, 0);
        check({tag, "_as"}, alloc_slot, 0);
        check({tag, "_at"}, alloc_tmpref, 0);
        check({tag, "_dv"}, display_valid, 0);
        check({tag, "_dr"}, display_repeat, 0);
        check({tag, "_ds"}, display_slot, 0);
        check({tag, "_st"}, stall, 0);
    endtask

    // Accept the outstanding offer, which must target slot f with the pending tmpref.
    task automatic take_offer(input int f);
        check("offer_valid", alloc_valid, 1);
        check("offer_slot", alloc_slot, f);
        check("offer_tmpref", alloc_tmpref, mptmp);
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
        mst[f] = A; mtmp[f] = mptmp; mgen[f] = m_gin; mpend = 0;
        check("offer_drop", alloc_valid, 0);
    endtask

    task automatic pic(input int t);
        int f;
        event_picture = 1'b1;
        tmpref = 10'(t);
        tick();
        event_picture = 1'b0;
        if (mpend != 0) begin
            check("drop_stall", stall, 1);
            return;
        end
        mpend = 1; mptmp = t;
        f = lowest_free();
        check("pic_t1_av", alloc_valid, 0);
        check("pic_t1_stall", stall, (f < 0) ? 1 : 0);
        tick();
        if (f < 0) begin
            check("stall_hold", stall, 1);
            check("stall_noalloc", alloc_valid, 0);
            return;
        end
        take_offer(f);
    endtask

    task automatic decode(input int s);
        decode_done = 1'b1;
        decode_slot = SW'(s);
        tick();
        decode_done = 1'b0;
        if (mst[s] == A) mst[s] = R;
    endtask

    task automatic gop();
        event_group_of_pictures = 1'b1;
        tick();
        event_group_of_pictures = 1'b0;
        m_gin = 1 - m_gin;
    endtask

    task automatic flush();
        event_sequence_header = 1'b1;
        tick();
        event_sequence_header = 1'b0;
        mdl_flush();
        check("flush_av", alloc_valid, 0);
        check("flush_stall", stall, 0);
    endtask

    task automatic do_vsync();
        int hit, lat, f;
        hit = find_hit();
        lat = 2;
        if (hit < 0 && !live_out() && m_gin != m_gout) begin
            m_gout = 1 - m_gout;
            m_exp = 0;
            hit = find_hit();
            lat = 4;
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        for (int k = 1; k < lat; k++) begin
            check("vs_wait_dv", display_valid, 0);
            check("vs_wait_dr", display_repeat, 0);
            tick();
        end
        if (hit >= 0) begin
            check("vs_valid", display_valid, 1);
            check("vs_repeat", display_repeat, 0);
            check("vs_slot", display_slot, hit);
            for (int i = 0; i < SLOTS; i++) if (mst[i] == SH) mst[i] = F;
            mst[hit] = SH;
            m_disp = hit;
            m_exp = (m_exp + 1) % 1024;
        end else begin
            check("vs_valid", display_valid, 0);
            check("vs_repeat", display_repeat, 1);
            check("vs_slot_hold", display_slot, m_disp);
            if (m_uf < 65535) m_uf++;
        end
`ifdef MPEG_DISPLAY_STATS_EN
        check("underflow_count", underflow_count, m_uf);
`endif
        tick();
        check("vs_end_dv", display_valid, 0);
        check("vs_end_dr", display_repeat, 0);
        if (mpend != 0) begin
            f = lowest_free();
            if (f >= 0) take_offer(f);
            else check("vs_still_stall", stall, 1);
        end
    endtask

    initial begin
        int f;
        int order[3];
        int t, op, sw_tmp, j;

        mdl_reset();
        tick();
        tick();
        check_zero_outputs("rst_hold");
        reset_n = 1'b1;
        tick();
        check_zero_outputs("rst_rel");

        // In-order display of an I,B,B group.
        gop();
        flush();
        pic(2); pic(0); pic(1);
        order[0] = 0; order[1] = 1; order[2] = 2;
        for (int i = 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            sw_tmp = order[i]; order[i] = order[j]; order[j] = sw_tmp;
        end
        for (int i = 0; i < 3; i++) decode(order[i]);
        do_vsync(); do_vsync(); do_vsync();

        // Fill every slot, stall on the next picture, drop one more, release via EMIT.
        pic(3); pic(4); pic(5);
        pic(6);
        pic(9);
        decode(1); decode(2); decode(3);
        do_vsync();

        // Repeat when the expected picture is still being decoded.
        do_vsync(); do_vsync();
        do_vsync();
        decode(0);
        do_vsync();

        // GOP boundary: switch generations and restart at tmpref 0.
        gop();
        pic(1); pic(0);
        for (int i = 0; i < SLOTS; i++) if (mst[i] == A) decode(i);
        do_vsync(); do_vsync();

        // Flush with READY and ALLOC slots; late decode_done is ignored.
        pic(2); pic(3); pic(4);
        t = 0;
        for (int i = 0; i < SLOTS; i++) if (mst[i] == A && t < 2) begin decode(i); t++; end
        f = -1;
        for (int i = 0; i < SLOTS; i++) if (mst[i] == A) f = i;
        flush();
        decode(f);
        do_vsync();

        // Outstanding offer withdrawn by a flush.
        event_picture = 1'b1; tmpref = 10'd0;
        tick();
        event_picture = 1'b0;
        tick();
        check("wd_offer", alloc_valid, 1);
        check("wd_slot", alloc_slot, lowest_free());
        flush();
        tick(); tick();
        check("wd_none", alloc_valid, 0);

        // Picture arriving together with a flush survives it.
        event_picture = 1'b1; tmpref = 10'd0; event_sequence_header = 1'b1;
        tick();
        event_picture = 1'b0; event_sequence_header = 1'b0;
        mdl_flush();
        mpend = 1; mptmp = 0;
        check("fp_t1", alloc_valid, 0);
        tick();
        take_offer(lowest_free());
        decode(find_hit() < 0 ? 0 : find_hit());
        for (int i = 0; i < SLOTS; i++) if (mst[i] == A) decode(i);
        do_vsync();

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 99);
            if (op < 35) begin
                t = $urandom_range(0, 4);
                if (m_gin == m_gout) t = (m_exp + t) % 1024;
                if (!dup_in(t)) pic(t);
            end else if (op < 60) begin
                decode($urandom_range(0, SLOTS - 1));
            end else if (op < 90) begin
                do_vsync();
            end else if (op < 95) begin
                gop();
            end else begin
                flush();
            end
        end

        // Reset asserted while an offer is outstanding.
        flush();
        f = lowest_free();
        event_picture = 1'b1; tmpref = 10'd7;
        tick();
        event_picture = 1'b0;
        tick();
        check("mid_offer", alloc_valid, 1);
        check("mid_slot", alloc_slot, f);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        tick();
        mdl_reset();
        reset_n = 1'b1;
        tick();
        pic(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
